// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and default constants for the multi-channel
//               SPI ADC capture block (capture FSM states, sample word type).
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

  localparam int ADC_DATA_WIDTH = 16;
  localparam int ADC_NUM_CH     = 4;

  typedef logic [ADC_DATA_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHIFT   = 2'd2,
    WRITE   = 2'd3
  } adc_cap_state_t;

endpackage
`default_nettype wire

// File: rtl/adc_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : adc_shift_reg
// Description : Serial-in / parallel-out register for one ADC channel.
//               Shifts MSB first (new bit enters at bit 0).
// Ports       : clk, rst (sync, active-low), clr (sync clear),
//               shift_en (shift sdi in this cycle), sdi (serial bit),
//               q (parallel sample, DATA_WIDTH >= 2)
// Revision    : 1.0 - initial release
// ============================================================================
module adc_shift_reg
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic                  sdi,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= {r_q[DATA_WIDTH-2:0], sdi};
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/adc_spi_capture.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_capture
// Description : Periodic capture from a simultaneous-sampling SPI ADC with one
//               SDO line per channel. Each frame: conversion pulse, serial
//               read-out of all channels in parallel, then one FIFO word per
//               clk for channels 0..NUM_CH-1. Never stalls: words offered
//               while fifo_full is high are dropped and flagged in overrun.
// Ports       : clk, rst (sync, active-low), enable, clr_status, test_mode,
//               adc_cnv, adc_sclk, adc_sdo[NUM_CH], fifo_data, fifo_write,
//               fifo_full, overrun, timing_err, frame_count[31:0]
// Options     : `define ADC_TEST_PATTERN_EN enables the test_mode pattern
//               {channel index, frame_count low bits}; otherwise test_mode
//               is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH    = ADC_DATA_WIDTH,
  parameter int NUM_CH        = ADC_NUM_CH,
  parameter int CLK_DIV       = 4,
  parameter int CONV_CYCLES   = 30,
  parameter int SAMPLE_PERIOD = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clr_status,
  input  logic                  test_mode,
  output logic                  adc_cnv,
  output logic                  adc_sclk,
  input  logic [NUM_CH-1:0]     adc_sdo,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_write,
  input  logic                  fifo_full,
  output logic                  overrun,
  output logic                  timing_err,
  output logic [31:0]           frame_count
);

  localparam int c_per_w   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int c_cnt_max = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_half_w  = $clog2(2 * DATA_WIDTH);
  localparam int c_k_w     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  adc_cap_state_t        r_state, w_state_nxt;
  logic [c_per_w-1:0]    r_period;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_half_w-1:0]   r_half;
  logic [c_k_w-1:0]      r_k;
  logic                  r_cnv, r_sclk, r_overrun, r_timing_err;
  logic [DATA_WIDTH-1:0] r_data_hold;
  logic [31:0]           r_frame_count;

  logic w_tick, w_frame_start, w_div_done, w_conv_done, w_last_half;
  logic w_shift_en, w_last_word, w_fifo_write;
  logic [DATA_WIDTH-1:0] w_samples [NUM_CH];
  logic [DATA_WIDTH-1:0] w_word;

  // Period counter: held at 0 while disabled so the first enabled cycle ticks.
  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      r_period <= '0;
    end else if (r_period == c_per_w'(SAMPLE_PERIOD - 1)) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + c_per_w'(1);
    end
  end

  assign w_tick        = enable && (r_period == '0);
  assign w_frame_start = w_tick && (r_state == IDLE);
  assign w_div_done    = (r_cnt == c_cnt_w'(CLK_DIV - 1));
  assign w_conv_done   = (r_cnt == c_cnt_w'(CONV_CYCLES - 1));
  assign w_last_half   = (r_half == c_half_w'(2 * DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_en   = 1'b0;
    w_last_word  = 1'b0;
    w_fifo_write = 1'b0;
    case (r_state)
      IDLE:    if (w_tick) w_state_nxt = CONVERT;
      CONVERT: if (w_conv_done) w_state_nxt = SHIFT;
      SHIFT: begin
        if (w_div_done) begin
          // Data is taken on the cycle SCLK is driven 0->1.
          w_shift_en = !r_sclk;
          if (w_last_half) w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        w_fifo_write = !fifo_full;
        if (r_k == c_k_w'(NUM_CH - 1)) begin
          w_last_word = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: phase counters, SPI pins, status and output hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_half        <= '0;
      r_k           <= '0;
      r_cnv         <= 1'b0;
      r_sclk        <= 1'b0;
      r_data_hold   <= '0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
      r_timing_err  <= 1'b0;
    end else begin
      r_cnv <= (w_state_nxt == CONVERT);
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_half <= '0;
          r_k    <= '0;
          r_sclk <= 1'b0;
        end
        CONVERT: r_cnt <= w_conv_done ? '0 : r_cnt + c_cnt_w'(1);
        SHIFT: begin
          if (w_div_done) begin
            r_cnt  <= '0;
            r_sclk <= !r_sclk;
            r_half <= w_last_half ? '0 : r_half + c_half_w'(1);
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        WRITE: begin
          r_k         <= w_last_word ? '0 : r_k + c_k_w'(1);
          r_data_hold <= w_word;
          if (w_last_word) r_frame_count <= r_frame_count + 32'd1;
        end
        default: r_cnt <= '0;
      endcase

      // Sticky flags: a set event in the same cycle beats clr_status.
      if (r_state == WRITE && fifo_full) r_overrun <= 1'b1;
      else if (clr_status)               r_overrun <= 1'b0;

      if (w_tick && r_state != IDLE) r_timing_err <= 1'b1;
      else if (clr_status)           r_timing_err <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    adc_shift_reg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_shift_reg (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_frame_start),
      .shift_en (w_shift_en),
      .sdi      (adc_sdo[gi]),
      .q        (w_samples[gi])
    );
  end

`ifdef ADC_TEST_PATTERN_EN
  localparam int c_ch_bits = $clog2(NUM_CH);
  logic [DATA_WIDTH-1:0] w_pattern;
  assign w_pattern = (DATA_WIDTH'(r_k) << (DATA_WIDTH - c_ch_bits))
                   | (r_frame_count[DATA_WIDTH-1:0] & ({DATA_WIDTH{1'b1}} >> c_ch_bits));
  assign w_word = test_mode ? w_pattern : w_samples[r_k];
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = test_mode;
  assign w_word = w_samples[r_k];
`endif

  assign adc_cnv     = r_cnv;
  assign adc_sclk    = r_sclk;
  assign fifo_write  = w_fifo_write;
  assign fifo_data   = (r_state == WRITE) ? w_word : r_data_hold;
  assign overrun     = r_overrun;
  assign timing_err  = r_timing_err;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_spi_capture
// Description : Directed self-checking bench for adc_spi_capture. A behavioural
//               ADC returns fixed per-channel words. A second instance with a
//               too-short SAMPLE_PERIOD shares the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_capture;
  import adc_pkg::*;

  logic clk = 1'b0;
  logic rst, enable, clr_status, test_mode, fifo_full;
  logic adc_cnv, adc_sclk, fifo_write, overrun, timing_err;
  logic [3:0]  adc_sdo;
  logic [15:0] fifo_data;
  logic [31:0] frame_count;

  logic s_cnv, s_sclk, s_fifo_write, s_overrun, s_timing_err;
  logic [3:0]  s_sdo;
  logic [15:0] s_fifo_data;
  logic [31:0] s_frame_count;

  sample_t adc_val [ADC_NUM_CH];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_spi_capture dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
    .test_mode(test_mode), .adc_cnv(adc_cnv), .adc_sclk(adc_sclk),
    .adc_sdo(adc_sdo), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .fifo_full(fifo_full), .overrun(overrun), .timing_err(timing_err),
    .frame_count(frame_count)
  );

  adc_spi_capture #(.SAMPLE_PERIOD(100)) dut_short (
    .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
    .test_mode(test_mode), .adc_cnv(s_cnv), .adc_sclk(s_sclk),
    .adc_sdo(s_sdo), .fifo_data(s_fifo_data), .fifo_write(s_fifo_write),
    .fifo_full(1'b0), .overrun(s_overrun), .timing_err(s_timing_err),
    .frame_count(s_frame_count)
  );

  // ADC model: MSB valid after conversion, next bit after each SCLK fall.
  int nfall_m = 0;
  int nfall_s = 0;
  always @(posedge adc_cnv or negedge adc_sclk) if (adc_cnv) nfall_m = 0; else nfall_m++;
  always @(posedge s_cnv or negedge s_sclk) if (s_cnv) nfall_s = 0; else nfall_s++;

  function automatic logic sdo_bit(input sample_t v, input int n);
    return (n >= 0 && n <= 15) ? v[15-n] : 1'b0;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_sdo
    assign adc_sdo[g] = sdo_bit(adc_val[g], nfall_m);
    assign s_sdo[g]   = sdo_bit(adc_val[g], nfall_s);
  end

  // Observers
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  logic [15:0] s_wr_data [$];
  int          cnv_rise [$];
  int cnv_run = 0, cnv_width = 0, sclk_total = 0;
  logic cnv_prev = 1'b0;

  always @(posedge adc_sclk) sclk_total++;

  always @(negedge clk) begin
    if (fifo_write === 1'b1) begin
      wr_data.push_back(fifo_data);
      wr_cyc.push_back(cyc);
    end
    if (s_fifo_write === 1'b1) s_wr_data.push_back(s_fifo_data);
    if (adc_cnv === 1'b1 && !cnv_prev) begin
      cnv_rise.push_back(cyc);
      cnv_run = 0;
    end
    if (adc_cnv === 1'b1) cnv_run++;
    if (adc_cnv === 1'b0 && cnv_prev) cnv_width = cnv_run;
    cnv_prev = (adc_cnv === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input int base, input int t0, input logic [15:0] e0,
                           input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    chk({tag, "_count"}, wr_data.size() - base, 4);
    if (wr_data.size() >= base + 4) begin
      chk({tag, "_lat"},  wr_cyc[base], t0 + 159);
      chk({tag, "_last"}, wr_cyc[base+3], t0 + 162);
      chk({tag, "_ch0"},  {16'h0, wr_data[base]},   {16'h0, e0});
      chk({tag, "_ch1"},  {16'h0, wr_data[base+1]}, {16'h0, e1});
      chk({tag, "_ch2"},  {16'h0, wr_data[base+2]}, {16'h0, e2});
      chk({tag, "_ch3"},  {16'h0, wr_data[base+3]}, {16'h0, e3});
    end
  endtask

  initial begin
    int t0, base, rb, sb, errs;
    adc_val[0] = 16'hA5A5; adc_val[1] = 16'h1234;
    adc_val[2] = 16'h0000; adc_val[3] = 16'hFFFF;
    rst = 1'b0; enable = 1'b0; clr_status = 1'b0; test_mode = 1'b0; fifo_full = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_cnv", adc_cnv, 0);
    chk("rst_sclk", adc_sclk, 0);
    chk("rst_wr", fifo_write, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_terr", timing_err, 0);
    chk("rst_fc", frame_count, 0);

    rst = 1'b1;
    step();

    // Continuous sampling: 5 frames, period 500
    enable = 1'b1; t0 = cyc; base = wr_data.size(); rb = cnv_rise.size(); sb = sclk_total;
    wait_until(t0 + 100);
    chk("short_terr_before", s_timing_err, 0);
    step();
    chk("short_terr_2nd_tick", s_timing_err, 1);
    wait_until(t0 + 170);
    chk_frame("f1", base, t0, 16'hA5A5, 16'h1234, 16'h0000, 16'hFFFF);
    chk("f1_fc", frame_count, 1);
    chk("f1_cnv_width", cnv_width, 30);
    chk("f1_sclk_rises", sclk_total - sb, 16);
    chk("f1_cnv_start", cnv_rise[rb], t0 + 1);
    wait_until(t0 + 2170);
    enable = 1'b0;
    step();
    chk("run_cnv_count", cnv_rise.size() - rb, 5);
    for (int i = 1; i < 5; i++) chk("run_period", cnv_rise[rb+i] - cnv_rise[rb+i-1], 500);
    chk("run_fc", frame_count, 5);
    chk("run_ovr", overrun, 0);
    chk("run_terr", timing_err, 0);
    chk("run_words", wr_data.size() - base, 20);
    chk("short_fc", s_frame_count, 11);
    chk("short_words", s_wr_data.size(), 44);
    errs = 0;
    foreach (s_wr_data[i]) if (s_wr_data[i] !== adc_val[i % 4]) errs++;
    chk("short_data", errs, 0);

    // FIFO full during channel 1 slot only
    enable = 1'b1; t0 = cyc; base = wr_data.size();
    step();
    enable = 1'b0;
    wait_until(t0 + 160);
    fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    wait_until(t0 + 170);
    chk("ovr_count", wr_data.size() - base, 3);
    chk("ovr_w0", wr_data[base],   16'hA5A5);
    chk("ovr_w1", wr_data[base+1], 16'h0000);
    chk("ovr_w2", wr_data[base+2], 16'hFFFF);
    chk("ovr_flag", overrun, 1);
    chk("ovr_fc", frame_count, 6);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // Enable dropped 10 cycles into SHIFT
    enable = 1'b1; t0 = cyc; base = wr_data.size(); rb = cnv_rise.size();
    wait_until(t0 + 41);
    enable = 1'b0;
    wait_until(t0 + 700);
    chk_frame("endrop", base, t0, 16'hA5A5, 16'h1234, 16'h0000, 16'hFFFF);
    chk("endrop_fc", frame_count, 7);
    chk("endrop_cnv_count", cnv_rise.size() - rb, 1);

    // Reset mid-SHIFT (SCLK is high at this point)
    enable = 1'b1; t0 = cyc;
    wait_until(t0 + 60);
    rst = 1'b0;
    step();
    chk("mrst_cnv", adc_cnv, 0);
    chk("mrst_sclk", adc_sclk, 0);
    chk("mrst_wr", fifo_write, 0);
    chk("mrst_data", fifo_data, 0);
    chk("mrst_ovr", overrun, 0);
    chk("mrst_terr", s_timing_err, 0);
    chk("mrst_fc", frame_count, 0);
    rst = 1'b1; t0 = cyc; base = wr_data.size();
    step();
    enable = 1'b0;
    wait_until(t0 + 170);
    chk_frame("restart", base, t0, 16'hA5A5, 16'h1234, 16'h0000, 16'hFFFF);
    chk("restart_fc", frame_count, 1);

    // Four more frames, then a test_mode frame with frame_count = 5
    for (int f = 0; f < 4; f++) begin
      enable = 1'b1; t0 = cyc;
      step();
      enable = 1'b0;
      wait_until(t0 + 170);
    end
    chk("pre_tm_fc", frame_count, 5);
    test_mode = 1'b1; enable = 1'b1; t0 = cyc; base = wr_data.size();
    step();
    enable = 1'b0;
    wait_until(t0 + 170);
`ifdef ADC_TEST_PATTERN_EN
    chk_frame("tmode", base, t0, 16'h0005, 16'h4005, 16'h8005, 16'hC005);
`else
    chk_frame("tmode", base, t0, 16'hA5A5, 16'h1234, 16'h0000, 16'hFFFF);
`endif
    chk("tmode_fc", frame_count, 6);
    test_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
